// File: rtl/vote_result_tx_if.sv
// Signal bundle between the voting-machine control path and the result transmitter.
// master = the side that supplies mode/start/tallies; slave = the transmitter itself.
interface vote_result_tx_if;
    logic       mode;
    logic       start;
    logic [7:0] candidate1_vote;
    logic [7:0] candidate2_vote;
    logic [7:0] candidate3_vote;
    logic [7:0] candidate4_vote;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output mode, start,
        output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        input  tx, busy, done
    );

    modport slave (
        input  mode, start,
        input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        output tx, busy, done
    );
endinterface

// File: rtl/vote_result_tx.sv
// Snapshots the four candidate tallies and sends them as a 7-byte UART 8N1 frame:
// HEADER, c1, c2, c3, c4, WIN, CHK.
module vote_result_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic             clock,
    input  logic             reset,
    vote_result_tx_if.slave  bus,
    output logic [2:0]       state_dbg
);
    // Request semantics: a frame is accepted on any edge where start && mode and the
    // FSM is IDLE; requests at any other time are dropped, never queued.
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [7:0]    snap1, snap2, snap3, snap4, win_q, chk_q;
    logic [7:0]    win_now, chk_now, cur_byte;
    logic          bit_end, accept;
    logic          tx_c, busy_c, done_c;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign accept  = (state == S_IDLE) && bus.start && bus.mode;

    // Winner is the strict maximum only; any tie at the top (including all zero) gives 0.
    always_comb begin
        win_now = 8'h00;
        if (bus.candidate1_vote > bus.candidate2_vote && bus.candidate1_vote > bus.candidate3_vote &&
            bus.candidate1_vote > bus.candidate4_vote)
            win_now = 8'd1;
        else if (bus.candidate2_vote > bus.candidate1_vote && bus.candidate2_vote > bus.candidate3_vote &&
                 bus.candidate2_vote > bus.candidate4_vote)
            win_now = 8'd2;
        else if (bus.candidate3_vote > bus.candidate1_vote && bus.candidate3_vote > bus.candidate2_vote &&
                 bus.candidate3_vote > bus.candidate4_vote)
            win_now = 8'd3;
        else if (bus.candidate4_vote > bus.candidate1_vote && bus.candidate4_vote > bus.candidate2_vote &&
                 bus.candidate4_vote > bus.candidate3_vote)
            win_now = 8'd4;
    end

    assign chk_now = HEADER ^ bus.candidate1_vote ^ bus.candidate2_vote ^
                     bus.candidate3_vote ^ bus.candidate4_vote ^ win_now;

    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = snap1;
            3'd2:    cur_byte = snap2;
            3'd3:    cur_byte = snap3;
            3'd4:    cur_byte = snap4;
            3'd5:    cur_byte = win_q;
            default: cur_byte = chk_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_c       = 1'b1;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && bus.mode) state_next = S_START;
            end
            S_START: begin
                tx_c   = 1'b0;
                busy_c = 1'b1;
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                tx_c   = cur_byte[bit_idx];
                busy_c = 1'b1;
                if (bit_end && bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: begin
                busy_c = 1'b1;
                if (bit_end) state_next = (byte_idx == 3'd6) ? S_DONE : S_START;
            end
            S_DONE: begin
                done_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            snap1    <= '0;
            snap2    <= '0;
            snap3    <= '0;
            snap4    <= '0;
            win_q    <= '0;
            chk_q    <= '0;
        end else begin
            if (busy_c && !bit_end) baud_cnt <= baud_cnt + 1'b1;
            else                    baud_cnt <= '0;
            if (state == S_DATA && bit_end) bit_idx  <= bit_idx + 1'b1;
            if (state == S_STOP && bit_end) byte_idx <= byte_idx + 1'b1;
            if (accept) begin
                bit_idx  <= '0;
                byte_idx <= '0;
                snap1    <= bus.candidate1_vote;
                snap2    <= bus.candidate2_vote;
                snap3    <= bus.candidate3_vote;
                snap4    <= bus.candidate4_vote;
                win_q    <= win_now;
                chk_q    <= chk_now;
            end
        end
    end

    assign bus.tx    = tx_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign state_dbg = state;
endmodule
